// File: rtl/rca_slice_sequencer.sv
// rca_slice_sequencer
//   Lets two requesters share one external SLICE_W-bit ripple-carry adder slice.
//   Each accepted operation is added SLICE_W bits per cycle, LSB slice first, with the
//   inter-slice carry held in a register. The full-width result is returned on a
//   valid/ready response channel. Round-robin arbitration decides which requester
//   is accepted when both are valid.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   req0_valid/ready        requester 0 handshake (ready is combinational, only in idle)
//   req0_a, req0_b, req0_cin operands and carry-in from requester 0
//   req1_*                  same set for requester 1
//   slice_a, slice_b        operand slices driven to the external adder (0 outside RUN)
//   slice_cin               carry into the external adder (0 outside RUN)
//   slice_s, slice_cout     combinational sum / carry-out returned by the adder
//   rsp_valid/ready         response handshake
//   rsp_id                  requester that issued the result
//   rsp_sum, rsp_cout       A+B+cin modulo 2^W and the final carry
//   busy                    high whenever an operation is in flight or awaiting pickup
module rca_slice_sequencer #(
  parameter int unsigned SLICE_W = 4,
  parameter int unsigned NSLICE  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req0_valid,
  output logic                        req0_ready,
  input  logic [SLICE_W*NSLICE-1:0]   req0_a,
  input  logic [SLICE_W*NSLICE-1:0]   req0_b,
  input  logic                        req0_cin,
  input  logic                        req1_valid,
  output logic                        req1_ready,
  input  logic [SLICE_W*NSLICE-1:0]   req1_a,
  input  logic [SLICE_W*NSLICE-1:0]   req1_b,
  input  logic                        req1_cin,
  output logic [SLICE_W-1:0]          slice_a,
  output logic [SLICE_W-1:0]          slice_b,
  output logic                        slice_cin,
  input  logic [SLICE_W-1:0]          slice_s,
  input  logic                        slice_cout,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_id,
  output logic [SLICE_W*NSLICE-1:0]   rsp_sum,
  output logic                        rsp_cout,
  output logic                        busy
);

  localparam int unsigned Width = SLICE_W * NSLICE;
  localparam int unsigned IdxW  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NSLICE - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e            state_q;
  logic [Width-1:0]  a_q;
  logic [Width-1:0]  b_q;
  logic [Width-1:0]  sum_q;
  logic [IdxW-1:0]   idx_q;
  logic              carry_q;
  logic              cout_q;
  logic              id_q;
  logic              last_q;   // requester granted most recently

  logic grant0;
  logic grant1;

  // Requester 0 wins unless requester 1 is also valid and 0 was served last.
  assign grant0 = req0_valid & (~req1_valid | last_q);
  assign grant1 = req1_valid & ~grant0;

  assign req0_ready = (state_q == StIdle) & grant0;
  assign req1_ready = (state_q == StIdle) & grant1;

  assign rsp_valid = (state_q == StDone);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign busy      = (state_q != StIdle);

  // Present the current slice to the external adder only while running.
  always_comb begin
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    if (state_q == StRun) begin
      slice_cin = carry_q;
      for (int i = 0; i < int'(NSLICE); i++) begin
        if (idx_q == IdxW'(i)) begin
          slice_a = a_q[i*SLICE_W +: SLICE_W];
          slice_b = b_q[i*SLICE_W +: SLICE_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant0 | grant1) begin
            a_q     <= grant1 ? req1_a : req0_a;
            b_q     <= grant1 ? req1_b : req0_b;
            carry_q <= grant1 ? req1_cin : req0_cin;
            id_q    <= grant1;
            last_q  <= grant1;
            idx_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          for (int i = 0; i < int'(NSLICE); i++) begin
            if (idx_q == IdxW'(i)) begin
              sum_q[i*SLICE_W +: SLICE_W] <= slice_s;
            end
          end
          carry_q <= slice_cout;
          if (idx_q == LastIdx) begin
            cout_q  <= slice_cout;
            idx_q   <= '0;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (rsp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_slice_sequencer.sv
// Bench for rca_slice_sequencer: an arithmetic/transaction model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_rca_slice_sequencer;

  localparam int unsigned SW = 4;
  localparam int unsigned NS = 4;
  localparam int unsigned W  = SW * NS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_cin = 1'b0, req1_cin = 1'b0;
  logic [SW-1:0] slice_a, slice_b, slice_s;
  logic         slice_cin, slice_cout;
  logic         rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_cout, busy;
  logic [W-1:0] rsp_sum;

  int n_vec = 0;
  int n_err = 0;

  rca_slice_sequencer #(.SLICE_W(SW), .NSLICE(NS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_s    (slice_s),
    .slice_cout (slice_cout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .busy       (busy)
  );

  // External adder slice.
  logic [SW:0] slice_full;
  assign slice_full = {1'b0, slice_a} + {1'b0, slice_b} + {{SW{1'b0}}, slice_cin};
  assign slice_s    = slice_full[SW-1:0];
  assign slice_cout = slice_full[SW];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one operation at a time, result ready NS edges after accept.
  logic        m_pending = 1'b0;
  int unsigned m_age = 0;
  int unsigned m_a = 0, m_b = 0, m_cin = 0;
  logic        m_id = 1'b0;
  logic        m_last = 1'b1;
  logic        m_g0, m_g1;
  assign m_g0 = req0_valid && (!req1_valid || m_last);
  assign m_g1 = req1_valid && !m_g0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending <= 1'b0;
      m_age     <= 0;
      m_last    <= 1'b1;
    end else if (m_pending) begin
      if (m_age >= NS) begin
        if (rsp_ready) m_pending <= 1'b0;
      end else begin
        m_age <= m_age + 1;
      end
    end else if (m_g0 || m_g1) begin
      m_pending <= 1'b1;
      m_age     <= 0;
      m_id      <= m_g1;
      m_last    <= m_g1;
      m_a       <= m_g1 ? int'(req1_a) : int'(req0_a);
      m_b       <= m_g1 ? int'(req1_b) : int'(req0_b);
      m_cin     <= m_g1 ? int'(req1_cin) : int'(req0_cin);
    end
  end

  bit   grant_log[$];
  logic rid_log[$];
  logic rcout_log[$];
  int   rsum_log[$];

  always @(negedge clk) begin
    if (rst_n) begin
      int unsigned full, mask, sh, exp_carry;
      full = m_a + m_b + m_cin;
      check("busy", busy, m_pending);
      check("rsp_valid", rsp_valid, m_pending && m_age >= NS);
      if (m_pending && m_age >= NS) begin
        check("rsp_id", rsp_id, m_id);
        check("rsp_sum", rsp_sum, full & 32'hFFFF);
        check("rsp_cout", rsp_cout, (full >> W) & 1);
      end
      if (m_pending && m_age < NS) begin
        sh = SW * m_age;
        mask = (32'd1 << sh) - 1;
        exp_carry = (((m_a & mask) + (m_b & mask) + m_cin) >> sh) & 1;
        check("slice_a", slice_a, (m_a >> sh) & 32'hF);
        check("slice_b", slice_b, (m_b >> sh) & 32'hF);
        check("slice_cin", slice_cin, exp_carry);
      end else begin
        check("slice_a_idle", slice_a, 0);
        check("slice_b_idle", slice_b, 0);
        check("slice_cin_idle", slice_cin, 0);
      end
      check("req0_ready", req0_ready, !m_pending && m_g0);
      check("req1_ready", req1_ready, !m_pending && m_g1);
      if (req0_valid && req0_ready) grant_log.push_back(1'b0);
      if (req1_valid && req1_ready) grant_log.push_back(1'b1);
      if (rsp_valid && rsp_ready) begin
        rid_log.push_back(rsp_id);
        rcout_log.push_back(rsp_cout);
        rsum_log.push_back(int'(rsp_sum));
      end
    end
  end

  // Present a request and return #1 after its accept edge with valid dropped.
  task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin);
    bit ok = 1'b0;
    if (id) begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((id ? req1_ready : req0_ready) == 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept", ok, 1);
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  // Count edges from the accept edge until rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      lat++;
      if (rsp_valid) break;
    end
    check("rsp_arrive", rsp_valid, 1);
  endtask

  initial begin
    int lat;
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle, nobody requesting.
    repeat (3) begin
      @(negedge clk);
      check("idle_slice_a", slice_a, 0);
      check("idle_slice_b", slice_b, 0);
      check("idle_slice_cin", slice_cin, 0);
      check("idle_busy", busy, 0);
      check("idle_rsp_valid", rsp_valid, 0);
    end

    // Basic addition and latency.
    issue(1'b0, 16'h1234, 16'h0FCD, 1'b0);
    wait_rsp(lat);
    check("t1_latency", lat, 4);
    check("t1_sum", rsp_sum, 32'h2201);
    check("t1_cout", rsp_cout, 0);
    check("t1_id", rsp_id, 0);
    @(posedge clk); #1;

    // Carry ripples through every slice.
    issue(1'b0, 16'hFFFF, 16'h0000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("t2_slice_cin", slice_cin, 1);
      @(posedge clk); #1;
    end
    check("t2_valid", rsp_valid, 1);
    check("t2_sum", rsp_sum, 32'h0000);
    check("t2_cout", rsp_cout, 1);
    @(posedge clk); #1;

    // Reinitialise the round-robin pointer, then contend continuously.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    grant_log.delete(); rid_log.delete(); rcout_log.delete(); rsum_log.delete();
    req0_a = 16'h0001; req0_b = 16'h0002; req0_cin = 1'b0;
    req1_a = 16'h8000; req1_b = 16'h8000; req1_cin = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (grant_log.size() >= 4) break;
    end
    check("t3_grants", grant_log.size(), 4);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rid_log.size() >= 4) break;
    end
    check("t3_rsps", rid_log.size(), 4);
    if (grant_log.size() >= 4 && rid_log.size() >= 4) begin
      check("t3_g0", grant_log[0], 0);
      check("t3_g1", grant_log[1], 1);
      check("t3_g2", grant_log[2], 0);
      check("t3_g3", grant_log[3], 1);
      check("t3_r0_sum", rsum_log[0], 32'h0003);
      check("t3_r1_id", rid_log[1], 1);
      check("t3_r1_sum", rsum_log[1], 32'h0000);
      check("t3_r1_cout", rcout_log[1], 1);
    end
    @(posedge clk); #1;

    // Back-pressure on the response side.
    rsp_ready = 1'b0;
    req1_a = 16'h4444; req1_b = 16'h1111; req1_valid = 1'b1;
    issue(1'b0, 16'h00FF, 16'h0001, 1'b0);
    wait_rsp(lat);
    req0_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t4_valid", rsp_valid, 1);
      check("t4_sum", rsp_sum, 32'h0100);
      check("t4_cout", rsp_cout, 0);
      check("t4_id", rsp_id, 0);
      check("t4_r0", req0_ready, 0);
      check("t4_r1", req1_ready, 0);
      check("t4_busy", busy, 1);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of an operation.
    issue(1'b0, 16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5_idx2_slice_a", slice_a, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_slice_a", slice_a, 0);
    check("t5_slice_b", slice_b, 0);
    check("t5_slice_cin", slice_cin, 0);
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_rsp_sum", rsp_sum, 0);
    check("t5_rsp_cout", rsp_cout, 0);
    check("t5_rsp_id", rsp_id, 0);
    check("t5_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("t5_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    req0_a = 16'h7FFF; req0_b = 16'h0001; req0_cin = 1'b0;
    req1_a = 16'h0005; req1_b = 16'h0005; req1_cin = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("t5_tie_r0", req0_ready, 1);
    check("t5_tie_r1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(lat);
    check("t5_sum", rsp_sum, 32'h8000);
    check("t5_id", rsp_id, 0);
    @(posedge clk); #1;

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
